// File: rtl/ddr_ctrl_pkg.sv
// Shared types and widths for the DDR command scheduler.
package ddr_ctrl_pkg;

    localparam int unsigned ROW_W  = 4;
    localparam int unsigned COL_W  = 12;
    localparam int unsigned DATA_W = 32;
    // Width of the shared timing down-counter; covers all timing parameters.
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [2:0] {
        CmdNop       = 3'd0,
        CmdRead      = 3'd1,
        CmdWrite     = 3'd2,
        CmdPrecharge = 3'd3,
        CmdActivate  = 3'd4,
        CmdRefresh   = 3'd5
    } cmd_e;

    typedef enum logic [3:0] {
        StInit,
        StIdle,
        StPre,
        StWaitRp,
        StAct,
        StWaitRcd,
        StRdWr,
        StRdWait,
        StRef,
        StWaitRfc
    } state_e;

endpackage

// File: rtl/ddr_refresh_timer.sv
// Free-running refresh interval counter. Raises a sticky pending flag once per
// interval; the scheduler clears it when it issues REFRESH.
module ddr_refresh_timer #(
    parameter int unsigned REF_INTERVAL = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ref_ack_i,
    output logic ref_set_o,
    output logic ref_pending_o
);

    localparam int unsigned CW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pending_q, pending_d;

    assign ref_set_o     = (cnt_q == CW'(REF_INTERVAL - 1));
    assign ref_pending_o = pending_q;

    // Wrap the counter at the interval end; a new set beats a same-cycle ack.
    always_comb begin
        cnt_d     = ref_set_o ? '0 : cnt_q + CW'(1);
        pending_d = pending_q;
        if (ref_ack_i) pending_d = 1'b0;
        if (ref_set_o) pending_d = 1'b1;
    end

    // Counter and pending flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/ddr_cmd_ctrl.sv
// Single-bank DDR command scheduler: open-row policy, periodic refresh,
// one outstanding host request, all outputs registered.
module ddr_cmd_ctrl
    import ddr_ctrl_pkg::*;
#(
    parameter int unsigned T_RCD        = 2,
    parameter int unsigned T_RP         = 2,
    parameter int unsigned T_RFC        = 4,
    parameter int unsigned CL           = 2,
    parameter int unsigned REF_INTERVAL = 64,
    parameter int unsigned INIT_CYC     = 8   // must be >= 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ROW_W-1:0]  req_row,
    input  logic [COL_W-1:0]  req_col,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [2:0]        cmd,
    output logic [ROW_W-1:0]  ra,
    output logic [COL_W-1:0]  ca,
    output logic [DATA_W-1:0] dq_out,
    output logic              dq_oe,
    output logic              r_w_enable,
    input  logic [DATA_W-1:0] dq_in
);

    // Counter loads: a wait state lasting N cycles is loaded with N-1.
    // INIT ends one edge early so req_ready rises on the INIT_CYC-th edge.
    localparam logic [CNT_W-1:0] InitLoad = CNT_W'(INIT_CYC - 2);
    localparam logic [CNT_W-1:0] RcdLoad  = CNT_W'(T_RCD - 2);
    localparam logic [CNT_W-1:0] RpLoad   = CNT_W'(T_RP - 2);
    localparam logic [CNT_W-1:0] RfcLoad  = CNT_W'(T_RFC - 1);
    localparam logic [CNT_W-1:0] ClLoad   = CNT_W'(CL);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic              we_q, ref_pre_q, open_q;
    logic [ROW_W-1:0]  row_q, open_row_q;
    logic [COL_W-1:0]  col_q;
    logic [DATA_W-1:0] wdata_q;

    cmd_e              cmd_q, cmd_d;
    logic [ROW_W-1:0]  ra_q, ra_d;
    logic [COL_W-1:0]  ca_q, ca_d;
    logic [DATA_W-1:0] dq_out_q, dq_out_d, rsp_rdata_q, rsp_rdata_d;
    logic              dq_oe_q, dq_oe_d, r_w_q, r_w_d;
    logic              ready_q, ready_d, rsp_valid_q, rsp_valid_d;

    logic ref_set, ref_pending, accept, wait_done;

    assign accept    = req_valid && ready_q;
    assign wait_done = (wait_q == '0);

    ddr_refresh_timer #(
        .REF_INTERVAL (REF_INTERVAL)
    ) u_ref_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .ref_ack_i     (state_q == StRef),
        .ref_set_o     (ref_set),
        .ref_pending_o (ref_pending)
    );

    // State and timing counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StInit;
            wait_q  <= InitLoad;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state: refresh is only taken from IDLE, so it never splits a request.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            StInit: begin
                if (wait_done) state_d = StIdle;
                else           wait_d  = wait_q - CNT_W'(1);
            end
            StIdle: begin
                if (ref_pending) begin
                    state_d = open_q ? StPre : StRef;
                end else if (accept) begin
                    if (!open_q)                   state_d = StAct;
                    else if (req_row == open_row_q) state_d = StRdWr;
                    else                           state_d = StPre;
                end
            end
            StPre: begin
                state_d = StWaitRp;
                wait_d  = RpLoad;
            end
            StWaitRp: begin
                if (wait_done) state_d = ref_pre_q ? StRef : StAct;
                else           wait_d  = wait_q - CNT_W'(1);
            end
            StAct: begin
                state_d = StWaitRcd;
                wait_d  = RcdLoad;
            end
            StWaitRcd: begin
                if (wait_done) state_d = StRdWr;
                else           wait_d  = wait_q - CNT_W'(1);
            end
            StRdWr: begin
                if (we_q) begin
                    state_d = StIdle;
                end else begin
                    state_d = StRdWait;
                    wait_d  = ClLoad;
                end
            end
            StRdWait: begin
                if (wait_done) state_d = StIdle;
                else           wait_d  = wait_q - CNT_W'(1);
            end
            StRef: begin
                state_d = StWaitRfc;
                wait_d  = RfcLoad;
            end
            StWaitRfc: begin
                if (wait_done) state_d = StIdle;
                else           wait_d  = wait_q - CNT_W'(1);
            end
            default: state_d = StInit;
        endcase
    end

    // Capture the accepted request and track which row is open.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            wdata_q    <= '0;
            ref_pre_q  <= 1'b0;
            open_q     <= 1'b0;
            open_row_q <= '0;
        end else begin
            if (state_q == StIdle) begin
                if (ref_pending) begin
                    ref_pre_q <= open_q;
                end else if (accept) begin
                    we_q      <= req_we;
                    row_q     <= req_row;
                    col_q     <= req_col;
                    wdata_q   <= req_wdata;
                    ref_pre_q <= 1'b0;
                end
            end
            if (state_q == StAct) begin
                open_q     <= 1'b1;
                open_row_q <= row_q;
            end
            if (state_q == StPre || state_q == StRef) open_q <= 1'b0;
        end
    end

    // Output decode: each command state lasts one cycle, so commands are one-cycle pulses.
    always_comb begin
        cmd_d       = CmdNop;
        ra_d        = ra_q;
        ca_d        = ca_q;
        dq_out_d    = '0;
        dq_oe_d     = 1'b0;
        r_w_d       = 1'b0;
        ready_d     = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        unique case (state_q)
            StIdle: ready_d = !accept && !ref_pending && !ref_set;
            StPre: begin
                cmd_d = CmdPrecharge;
                ra_d  = open_row_q;
            end
            StAct: begin
                cmd_d = CmdActivate;
                ra_d  = row_q;
            end
            StRdWr: begin
                ra_d = row_q;
                ca_d = col_q;
                if (we_q) begin
                    cmd_d    = CmdWrite;
                    dq_out_d = wdata_q;
                    dq_oe_d  = 1'b1;
                end else begin
                    cmd_d = CmdRead;
                    r_w_d = 1'b1;
                end
            end
            StRdWait: begin
                r_w_d = 1'b1;
                if (wait_done) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = dq_in;
                end
            end
            StRef: cmd_d = CmdRefresh;
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q       <= CmdNop;
            ra_q        <= '0;
            ca_q        <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            r_w_q       <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            cmd_q       <= cmd_d;
            ra_q        <= ra_d;
            ca_q        <= ca_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            r_w_q       <= r_w_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign cmd        = cmd_q;
    assign ra         = ra_q;
    assign ca         = ca_q;
    assign dq_out     = dq_out_q;
    assign dq_oe      = dq_oe_q;
    assign r_w_enable = r_w_q;
    assign req_ready  = ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;

endmodule

// File: doc/ddr_cmd_ctrl.md
# ddr_cmd_ctrl

Command scheduler that sits directly upstream of the DDR memory model on the memory interface. It accepts single-word read/write requests from the host side over a valid/ready handshake and turns them into one-cycle ACTIVATE / READ / WRITE / PRECHARGE / REFRESH commands separated by NOPs. It keeps one row open between requests, inserts periodic refresh, and returns read data after the CAS latency.

## Interface
Parameters:
- T_RCD, 2, cycles from ACTIVATE edge to READ/WRITE edge (≥2)
- T_RP, 2, cycles from PRECHARGE edge to next ACTIVATE/REFRESH edge (≥2)
- T_RFC, 4, cycles from REFRESH edge to next command edge (≥2)
- CL, 2, memory read latency in cycles
- REF_INTERVAL, 64, cycles between refresh requests
- INIT_CYC, 8, NOP cycles after reset before the first request is accepted

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  host request valid
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = write, 0 = read
- req_row  in  4  row address
- req_col  in  12  column address
- req_wdata  in  32  write data
- rsp_valid  out  1  one-cycle pulse, read data valid
- rsp_rdata  out  32  read data
- cmd  out  3  memory command: 0 NOP, 1 READ, 2 WRITE, 3 PRECHARGE, 4 ACTIVATE, 5 REFRESH
- ra  out  4  row address to memory
- ca  out  12  column address to memory
- dq_out  out  32  write data toward memory
- dq_oe  out  1  controller drives dq (WRITE cycle only)
- r_w_enable  out  1  memory drives dq (read window)
- dq_in  in  32  data bus as seen from memory

## Operation
- All outputs are registered. Reset values: cmd=0 (NOP), ra=0, ca=0, dq_out=0, dq_oe=0, r_w_enable=0, req_ready=0, rsp_valid=0, rsp_rdata=0. On reset the open-row flag is cleared and the refresh counter is zeroed.
- Every non-NOP command lasts exactly one cycle and is followed by at least one NOP cycle, because the memory reacts to cmd/ca changes.
- States:
  - INIT: holds for INIT_CYC cycles, then goes to IDLE.
  - IDLE: req_ready=1 only if no refresh is pending. A request is accepted on req_valid&&req_ready, and its fields are captured.
  - Accepted request, routed by row state:
    - Row hit (open flag set and req_row==open_row): go to RDWR.
    - No row open: go to ACT.
    - Other row open: go to PRE, then ACT.
  - ACT → WAIT_RCD → RDWR.
  - PRE → WAIT_RP → ACT, or → REF when the precharge was issued for a refresh.
  - RDWR issues READ or WRITE.
    - WRITE: dq_out=wdata and dq_oe=1 for that cycle only, then return to IDLE.
    - READ: go to RD_WAIT.
  - RD_WAIT: r_w_enable=1 from the READ edge through the sample edge.
  - REF → WAIT_RFC → IDLE.
- Refresh counter: ref_pending is set when the counter reaches REF_INTERVAL-1, then the counter wraps to 0.
  - In IDLE, a pending refresh beats a new request, and req_ready drops in the cycle ref_pending is set.
  - If a row is open, the controller issues PRE first; REFRESH closes the row.
  - A refresh that falls due mid-request waits until the request completes.
- Simultaneous refresh due and req_valid in IDLE: refresh wins and the request waits. The host must hold req_valid and its fields stable until accepted.
- Reset asserted mid-operation: all outputs return to reset values immediately, no rsp_valid is produced, and the FSM restarts in INIT.

## Timing
- Accept at edge A (IDLE). The first command is launched at edge A+1.
- ACTIVATE at edge E → READ/WRITE at E+T_RCD. PRECHARGE at E → ACTIVATE/REFRESH at E+T_RP. REFRESH at E → IDLE at E+T_RFC.
- READ at edge R: dq_in sampled at edge R+CL+1, where rsp_rdata<=dq_in and rsp_valid<=1 for one cycle. r_w_enable falls at R+CL+2.
- req_ready re-asserts:
  - after a read, at the edge after rsp_valid;
  - after a write, at the edge after the WRITE edge.
- One outstanding request maximum.

## Structure
- Package ddr_ctrl_pkg holds:
  - cmd_e enum (NOP=0, READ=1, WRITE=2, PRECHARGE=3, ACTIVATE=4, REFRESH=5);
  - state_e enum;
  - ROW_W=4, COL_W=12, DATA_W=32.
- Sub-module ddr_refresh_timer: REF_INTERVAL counter with ref_pending set and ref_ack clear.
- The top-level wrapper maps dq_out/dq_oe/dq_in onto the tri-state dq of mem_intf. This block drives no tri-state itself.

## Test plan
All scenarios use default parameters.
- Cold read: after reset, cmd=NOP for 8 cycles and req_ready rises. Read row 3 col 0x010 accepted at A → ACTIVATE ra=3 at A+1, READ ca=0x010 at A+3, rsp_valid with stored data at A+6.
- Row-hit write then read: write row 3 col 5 data 0xDEADBEEF → WRITE at A+1 with dq_oe=1 and no ACTIVATE. Next read of row 3 col 5 → READ at B+1, rsp_rdata=0xDEADBEEF at B+4.
- Row miss: row 3 open, read row 7 → PRECHARGE at A+1, ACTIVATE ra=7 at A+3, READ at A+5.
- Refresh: idle with row open → PRECHARGE then REFRESH 2 cycles later, with req_ready=0 throughout. A request held during refresh is accepted only after WAIT_RFC and needs a fresh ACTIVATE.
- Collision: req_valid rises in the same cycle ref_pending sets → REFRESH sequence first, then the request completes with correct data.
- Reset mid-read: rst_n low in RD_WAIT → cmd=0, r_w_enable=0, req_ready=0 immediately. No rsp_valid. After release, 8 NOP cycles, then a row-hit request still issues ACTIVATE because the open row was cleared.
